// File: rtl/uart_pkg.sv
// Shared UART types and helpers: FSM state encodings, line idle level, counter-width function.
// No logic of its own; imported by uart_fifo and uart_core.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic UART_IDLE_LVL = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead FIFO (DEPTH a power of 2): rdata is the head entry, and is zero while empty.
// A push is refused when full unless a pop happens in the same cycle; a pop is refused when empty.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // The extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART with TX/RX FIFOs; UART_PARITY_EN adds a parity bit. tx goes low 2 cycles after a push;
// an RX byte is readable the cycle after the first stop-bit mid-sample. wr_rdy=0 when TX FIFO full; full RX FIFO drops bytes.
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    output logic              wr_rdy,
    output logic [DATA_W-1:0] dout,
    input  logic              rd_en,
    output logic              rd_rdy,
    output logic              tx,
    input  logic              rx,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    localparam int CW = clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BW = clog2(DATA_W);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID      = CW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);
`ifdef UART_PARITY_EN
    localparam tx_state_t TX_AFTER_DATA = TX_PARITY;
    localparam rx_state_t RX_AFTER_DATA = RX_PARITY;
`else
    localparam tx_state_t TX_AFTER_DATA = TX_STOP;
    localparam rx_state_t RX_AFTER_DATA = RX_STOP;
`endif

    logic              tx_full, tx_empty, tx_pop, tx_push;
    logic [DATA_W-1:0] tx_fifo_dat;
    logic              rx_full, rx_empty, rx_push;

    tx_state_t         tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_q, tx_d;

    rx_state_t         rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_par_bad_q, rx_par_bad_d;
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              parity_err_q, parity_err_d;

    assign tx_push    = wr_en && !tx_full;
    assign wr_rdy     = !tx_full;
    assign rd_rdy     = !rx_empty;
    assign tx         = tx_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign parity_err = parity_err_q;

    uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop),
        .wdata(din), .rdata(tx_fifo_dat), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rd_en),
        .wdata(rx_data_q), .rdata(dout), .full(rx_full), .empty(rx_empty)
    );

    // tx_q is registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_data_d  = tx_data_q;
        tx_pop     = 1'b0;
        tx_d       = UART_IDLE_LVL;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_data_d  = tx_fifo_dat;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_d = 1'b0;
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_d = tx_data_q[tx_bit_q];
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + BW'(1);
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = TX_AFTER_DATA;
                    end
                end
            end
            TX_PARITY: begin
                tx_d = ^tx_data_q ^ PAR_ODD;
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == STOP_END) begin
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_data_d  = tx_fifo_dat;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Counter starts at 1 on detection so bit samples land at CLKS_PER_BIT/2 after each pin transition.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + CW'(1);
        rx_bit_d     = rx_bit_q;
        rx_data_d    = rx_data_q;
        rx_par_bad_d = rx_par_bad_q;
        rx_push      = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        parity_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = CW'(1);
                if (rx_prev_q && !rx_sync_q) begin
                    rx_par_bad_d = 1'b0;
                    rx_state_d   = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == MID && rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == MID) begin
                    rx_data_d[rx_bit_q] = rx_sync_q;
                end
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = '0;
                    rx_bit_d = rx_bit_q + BW'(1);
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = RX_AFTER_DATA;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q == MID) begin
                    rx_par_bad_d = (rx_sync_q != (^rx_data_q ^ PAR_ODD));
                end
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == MID) begin
                    rx_state_d  = RX_IDLE;
                    frame_err_d = !rx_sync_q;
`ifdef UART_PARITY_EN
                    parity_err_d = rx_par_bad_q;
`endif
                    rx_push   = rx_sync_q && !rx_par_bad_q;
                    overrun_d = rx_push && rx_full && !rd_en;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_data_q    <= '0;
            tx_q         <= UART_IDLE_LVL;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_data_q    <= '0;
            rx_par_bad_q <= 1'b0;
            rx_meta_q    <= UART_IDLE_LVL;
            rx_sync_q    <= UART_IDLE_LVL;
            rx_prev_q    <= UART_IDLE_LVL;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_data_q    <= tx_data_d;
            tx_q         <= tx_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_data_q    <= rx_data_d;
            rx_par_bad_q <= rx_par_bad_d;
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: loopback, TX burst, RX glitch, framing, overrun, parity and async reset.
// Inputs driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_uart_core;

    localparam int DW    = 8;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = (1 + DW + PB + 1) * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          wr_en = 1'b0;
    logic          wr_rdy;
    logic [DW-1:0] dout;
    logic          rd_en = 1'b0;
    logic          rd_rdy;
    logic          tx;
    logic          rx;
    logic          frame_err, overrun, parity_err;
    logic          use_loop = 1'b1;
    logic          inj = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int cyc_cnt = 0;

    assign rx = use_loop ? tx : inj;

    uart_core #(
        .DATA_W(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .wr_rdy(wr_rdy),
        .dout(dout), .rd_en(rd_en), .rd_rdy(rd_rdy), .tx(tx), .rx(rx),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (parity_err === 1'b1) pe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic wait_tx_low(input string tag, output int t0);
        int t;
        t = 0;
        while (tx && t < 4 * FRAME) begin
            @(negedge clk);
            t++;
        end
        check(tag, tx, 0);
        t0 = cyc_cnt;
    endtask

    // t0 is cyc_cnt at the first falling-edge sample where tx was low.
    task automatic grab_tx(input int t0, output logic [DW-1:0] d);
        for (int i = 0; i < DW; i++) begin
            while (cyc_cnt < t0 + CPB / 2 + CPB * (i + 1)) @(negedge clk);
            d[i] = tx;
        end
        while (cyc_cnt < t0 + CPB / 2 + CPB * (DW + PB + 1)) @(negedge clk);
        check("tx_stop_bit", tx, 1);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_v, input logic par_v);
        inj = 1'b0;
        cyc(CPB);
        for (int i = 0; i < DW; i++) begin
            inj = d[i];
            cyc(CPB);
        end
        if (PB != 0) begin
            inj = par_v;
            cyc(CPB);
        end
        inj = stop_v;
        cyc(CPB);
        inj = 1'b1;
        cyc(CPB);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0]   fr;
        logic [DW-1:0] d;
        logic [4:0]    par_a;
        int            acc, t_fall, t_prev, t0, hi, cnt0;

        // Reset state
        cyc(3);
        check("rst_tx", tx, 1);
        check("rst_wr_rdy", wr_rdy, 1);
        check("rst_rd_rdy", rd_rdy, 0);
        check("rst_dout", dout, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity_err", parity_err, 0);
        rst_n = 1'b1;
        cyc(2);

        // Loopback 0x7D: start, 1,0,1,1,1,1,1,0, [parity 0], stop
`ifdef UART_PARITY_EN
        fr = {1'b1, 1'b0, 8'h7D, 1'b0};
`else
        fr = {1'b1, 1'b1, 8'h7D, 1'b0};
`endif
        din = 8'h7D;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        check("lb_tx_after_k", tx, 1);
        @(negedge clk);
        check("lb_tx_after_k1", tx, 1);
        @(negedge clk);
        for (int b = 0; b < 10 + PB; b++) begin
            if (b > 0) @(negedge clk);
            check($sformatf("lb_bit%0d_first", b), tx, fr[b]);
            repeat (CPB - 1) @(negedge clk);
            check($sformatf("lb_bit%0d_last", b), tx, fr[b]);
        end
        t0 = 0;
        while (!rd_rdy && t0 < 2 * FRAME) begin
            @(negedge clk);
            t0++;
        end
        check("lb_rd_rdy", rd_rdy, 1);
        check("lb_dout", dout, 8'h7D);
        pop_one();
        check("lb_rd_rdy_after_pop", rd_rdy, 0);
        check("lb_no_frame_err", fe_cnt, 0);

        // Burst of 8 writes into a 4-deep TX FIFO
        use_loop = 1'b0;
        cyc(4);
        acc = 0;
        t_fall = -1;
        for (int i = 0; i < 8; i++) begin
            din = 8'(i + 1);
            wr_en = 1'b1;
            if (wr_rdy) acc++;
            @(negedge clk);
            if (!tx && t_fall < 0) t_fall = cyc_cnt;
        end
        wr_en = 1'b0;
        check("burst_accepted", acc, 5);
        check("burst_wr_rdy_low", wr_rdy, 0);
        check("burst_started", (t_fall >= 0), 1);
        grab_tx(t_fall, d);
        check("burst_byte1", d, 8'h01);
        check("burst_wr_rdy_frame1", wr_rdy, 0);
        t_prev = t_fall;
        for (int f = 2; f <= 5; f++) begin
            wait_tx_low($sformatf("burst_start%0d", f), t0);
            check($sformatf("burst_gap%0d", f), t0 - t_prev, FRAME);
            if (f == 2) check("burst_wr_rdy_frame2", wr_rdy, 1);
            grab_tx(t0, d);
            check($sformatf("burst_byte%0d", f), d, 32'(f));
            t_prev = t0;
        end
        hi = 1;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (!tx) hi = 0;
        end
        check("burst_no_sixth_frame", hi, 1);

        // Start-bit glitch of 7 cycles
        cnt0 = fe_cnt;
        inj = 1'b0;
        cyc(7);
        inj = 1'b1;
        cyc(40);
        check("glitch_no_push", rd_rdy, 0);
        check("glitch_no_frame_err", fe_cnt - cnt0, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("glitch_recover_rdy", rd_rdy, 1);
        check("glitch_recover_dout", dout, 8'h3C);
        pop_one();

        // Framing error on 0x55
        cnt0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        check("ferr_pulse_count", fe_cnt - cnt0, 1);
        check("ferr_dropped", rd_rdy, 0);

        // Overrun: five frames into a 4-deep RX FIFO
        par_a = 5'b10110;
        cnt0 = ov_cnt;
        for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1'b1, par_a[i]);
        check("ovr_none_before_5th", ov_cnt - cnt0, 0);
        send_frame(8'hA4, 1'b1, par_a[4]);
        check("ovr_pulse_5th", ov_cnt - cnt0, 1);
        check("ovr_head", dout, 8'hA0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovr_pop%0d", i), dout, 8'hA0 + 8'(i));
            pop_one();
        end
        check("ovr_drained", rd_rdy, 0);

`ifdef UART_PARITY_EN
        cnt0 = pe_cnt;
        send_frame(8'h2F, 1'b1, 1'b0);
        check("par_err_pulse", pe_cnt - cnt0, 1);
        check("par_err_dropped", rd_rdy, 0);
`else
        check("par_err_tied_low", pe_cnt, 0);
`endif

        // Asynchronous reset in the middle of a TX frame
        send_frame(8'h99, 1'b1, 1'b0);
        check("rst_pre_rd_rdy", rd_rdy, 1);
        for (int i = 0; i < 5; i++) begin
            din = 8'h00;
            wr_en = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("rst_pre_wr_rdy", wr_rdy, 0);
        cyc(20);
        check("rst_pre_tx_low", tx, 0);
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", tx, 1);
        check("rst_async_wr_rdy", wr_rdy, 1);
        check("rst_async_rd_rdy", rd_rdy, 0);
        check("rst_async_dout", dout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hi = 1;
        repeat (FRAME) begin
            @(negedge clk);
            if (!tx) hi = 0;
        end
        check("rst_tx_stays_idle", hi, 1);
        check("rst_no_overrun_total", ov_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
